// File: rtl/serial_sub32_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_pkg;

  // Controller states: waiting for operands, stepping digits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH   = 32'd32;
  localparam int unsigned DEF_DIGIT_W = 32'd1;

  // Number of digit steps needed to cover the full operand width.
  function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit_w);
    return width / digit_w;
  endfunction

  // Digit counter width; never narrower than one bit so a single-digit
  // configuration still has a legal counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub32_slice.sv
// One DIGIT_W-bit subtract step, built on an adder: x + ~y + !bin.
// The adder carry-out is the inverse of the borrow.
module sub_slice #(
  parameter int unsigned DIGIT_W = 32'd1
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] sum_s;

  assign sum_s = {1'b0, x} + {1'b0, ~y} + {{DIGIT_W{1'b0}}, ~bin};
  assign d     = sum_s[DIGIT_W-1:0];
  assign bout  = ~sum_s[DIGIT_W];

endmodule

// File: rtl/serial_sub32.sv
// Digit-serial a - b: one narrow subtract slice, operand shift registers,
// a registered borrow and a small IDLE/RUN/DONE controller with valid/ready
// on both sides. Result flags are captured on the final digit step.
module serial_sub32
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned N  = num_digits(WIDTH, DIGIT_W);
  localparam int unsigned CW = cnt_width(N);

  generate
    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
      $error("serial_sub32: WIDTH must be a multiple of DIGIT_W");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;

  logic [DIGIT_W-1:0] slice_d_s;
  logic               slice_bout_s, slice_bin_s, last_s;
  logic [WIDTH-1:0]   res_next_s;

  // First digit never sees a borrow, whatever the register holds.
  assign slice_bin_s = (cnt_q == {CW{1'b0}}) ? 1'b0 : borrow_q;
  assign last_s      = (cnt_q == CW'(N - 32'd1));
  assign res_next_s  = {slice_d_s, res_q[WIDTH-1:DIGIT_W]};

  sub_slice #(.DIGIT_W(DIGIT_W)) u_slice (
    .x    (a_sh_q[DIGIT_W-1:0]),
    .y    (b_sh_q[DIGIT_W-1:0]),
    .bin  (slice_bin_s),
    .d    (slice_d_s),
    .bout (slice_bout_s)
  );

  // Next-state, datapath shifting and result capture.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_d    = {WIDTH{1'b0}};
          cnt_d    = {CW{1'b0}};
          borrow_d = 1'b0;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = {{DIGIT_W{1'b0}}, a_sh_q[WIDTH-1:DIGIT_W]};
        b_sh_d   = {{DIGIT_W{1'b0}}, b_sh_q[WIDTH-1:DIGIT_W]};
        res_d    = res_next_s;
        borrow_d = slice_bout_s;
        if (last_s) begin
          cnt_d   = {CW{1'b0}};
          diff_d  = res_next_s;
          bout_d  = slice_bout_s;
          zero_d  = (res_next_s == {WIDTH{1'b0}});
          ovf_d   = (a_msb_q != b_msb_q) && (res_next_s[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_sub32.sv
// Bench for serial_sub32: a DIGIT_W=1 and a DIGIT_W=4 instance checked
// against a plain-arithmetic reference of a - b.
module tb_serial_sub32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, bout1, zero1, ovf1;
  logic [31:0] a1, b1, diff1;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, bout4, zero4, ovf4;
  logic [31:0] a4, b4, diff4;

  int n_tests = 0;
  int n_fail  = 0;

  serial_sub32 #(.WIDTH(32), .DIGIT_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .borrow_out(bout1), .zero(zero1), .ovf(ovf1)
  );

  serial_sub32 #(.WIDTH(32), .DIGIT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .borrow_out(bout4), .zero(zero4), .ovf(ovf4)
  );

  // Reference: unsigned difference, unsigned borrow, signed overflow by range.
  function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] d, output logic br,
                                  output logic z, output logic o);
    longint sr;
    d  = x - y;
    br = (x < y);
    z  = (d == 32'd0);
    sr = longint'($signed(x)) - longint'($signed(y));
    o  = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
  endfunction

  // Present operands for one edge, then scramble the inputs.
  task automatic drive(input bit sel, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    if (sel) begin a4 = x; b4 = y; in_valid4 = 1'b1; end
    else     begin a1 = x; b1 = y; in_valid1 = 1'b1; end
    @(posedge clk); #1;
    if (sel) begin in_valid4 = 1'b0; a4 = $urandom; b4 = $urandom; end
    else     begin in_valid1 = 1'b0; a1 = $urandom; b1 = $urandom; end
  endtask

  task automatic wait_valid(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? out_valid4 : out_valid1) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic xfer(input bit sel);
    if (sel) out_ready4 = 1'b1; else out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    out_ready1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid1 = 1'b0; in_valid4 = 1'b0; out_ready1 = 1'b0; out_ready4 = 1'b0;
    a1 = 32'd0; b1 = 32'd0; a4 = 32'd0; b4 = 32'd0;
    #12;
    n_tests++;
    if ({in_ready1, out_valid1, diff1, bout1, zero1, ovf1} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_w1: got rdy=%b vld=%b diff=%h b=%b z=%b o=%b expected 1 0 0 0 0 0",
               in_ready1, out_valid1, diff1, bout1, zero1, ovf1);
    end
    n_tests++;
    if ({in_ready4, out_valid4, diff4, bout4, zero4, ovf4} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_w4: got rdy=%b vld=%b diff=%h b=%b z=%b o=%b expected 1 0 0 0 0 0",
               in_ready4, out_valid4, diff4, bout4, zero4, ovf4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({in_ready1, out_valid1} !== 2'b10) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy/vld=%b expected 10", {in_ready1, out_valid1});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'd5, 32'd0, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] tb [4] = '{32'd3, 32'd1, 32'd1,        32'hFFFFFFFF};
    logic [31:0] td [4] = '{32'd2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    logic [2:0]  tf [4] = '{3'b000, 3'b100, 3'b001, 3'b101};  // {borrow, zero, ovf}
    int lat;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ta[i], tb[i]);
      wait_valid(1'b0, lat);
      n_tests++;
      if (lat !== 32) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d expected 32", i, lat);
      end
      n_tests++;
      if ({diff1, bout1, zero1, ovf1} !== {td[i], tf[i]}) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got diff=%h bzo=%b%b%b expected diff=%h bzo=%b",
                 i, diff1, bout1, zero1, ovf1, td[i], tf[i]);
      end
      xfer(1'b0);
      n_tests++;
      if ({out_valid1, in_ready1} !== 2'b01) begin
        n_fail++;
        $display("FAIL dir_handoff[%0d]: got vld/rdy=%b expected 01", i, {out_valid1, in_ready1});
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [31:0] d0;
    drive(1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL run_in_ready: got %b expected 0", in_ready1);
    end
    in_valid1 = 1'b1; a1 = 32'd1; b1 = 32'd0;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    wait_valid(1'b0, lat);
    n_tests++;
    if (lat + 5 !== 32) begin
      n_fail++;
      $display("FAIL hold_latency: got %0d expected 32", lat + 5);
    end
    n_tests++;
    if ({diff1, bout1, zero1, ovf1} !== {32'd0, 3'b010}) begin
      n_fail++;
      $display("FAIL hold_result: got diff=%h bzo=%b%b%b expected 0 010", diff1, bout1, zero1, ovf1);
    end
    d0 = diff1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid1, in_ready1, diff1, zero1} !== {2'b10, d0, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b diff=%h z=%b expected 1 0 %h 1",
                 c, out_valid1, in_ready1, diff1, zero1, d0);
      end
    end
    // Offer new operands in the transfer cycle: they must not be taken.
    in_valid1 = 1'b1; a1 = 32'd7; b1 = 32'd2; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    n_tests++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      n_fail++;
      $display("FAIL no_accept_on_xfer: got vld/rdy=%b expected 01", {out_valid1, in_ready1});
    end
    @(posedge clk); #1;
    n_tests++;
    if (in_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL no_queue: got in_ready=%b expected 1", in_ready1);
    end
  endtask

  task automatic test_random(input bit sel, input int count);
    logic [31:0] x, y, ed;
    logic eb, ez, eo;
    int lat, exp_lat;
    exp_lat = sel ? 8 : 32;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 3))
        0:       begin x = $urandom; y = x; end
        1:       begin x = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'h0}; y = $urandom; end
        default: begin x = $urandom; y = $urandom; end
      endcase
      ref_sub(x, y, ed, eb, ez, eo);
      drive(sel, x, y);
      wait_valid(sel, lat);
      n_tests++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL rnd_latency[w%0d,%0d]: got %0d expected %0d", sel ? 4 : 1, i, lat, exp_lat);
      end
      n_tests++;
      if (sel ? ({diff4, bout4, zero4, ovf4} !== {ed, eb, ez, eo})
              : ({diff1, bout1, zero1, ovf1} !== {ed, eb, ez, eo})) begin
        n_fail++;
        $display("FAIL rnd_result[w%0d,%0d]: a=%h b=%h got diff=%h bzo=%b expected diff=%h bzo=%b%b%b",
                 sel ? 4 : 1, i, x, y, sel ? diff4 : diff1,
                 sel ? {bout4, zero4, ovf4} : {bout1, zero1, ovf1}, ed, eb, ez, eo);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      xfer(sel);
    end
  endtask

  task automatic test_digit4();
    int lat;
    drive(1'b1, 32'h12345678, 32'h11111111);
    wait_valid(1'b1, lat);
    n_tests++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL w4_latency: got %0d expected 8", lat);
    end
    n_tests++;
    if ({diff4, bout4} !== {32'h01234567, 1'b0}) begin
      n_fail++;
      $display("FAIL w4_result: got diff=%h b=%b expected 01234567 0", diff4, bout4);
    end
    xfer(1'b1);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    drive(1'b0, 32'd100, 32'd1);
    wait_valid(1'b0, lat);
    xfer(1'b0);
    drive(1'b0, $urandom, $urandom);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid1, in_ready1, diff1, bout1, zero1, ovf1} !== {2'b01, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b rdy=%b diff=%h bzo=%b%b%b expected 0 1 0 000",
               out_valid1, in_ready1, diff1, bout1, zero1, ovf1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'd10, 32'd4);
    wait_valid(1'b0, lat);
    n_tests++;
    if (lat !== 32 || diff1 !== 32'd6) begin
      n_fail++;
      $display("FAIL after_reset: got lat=%0d diff=%h expected 32 00000006", lat, diff1);
    end
    xfer(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_digit4();
    test_random(1'b0, 12);
    test_random(1'b1, 12);
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub32.md
Name: serial_sub32

Overview:
- Multicycle 32-bit subtractor, the inverse operation of the team's combinational 32-bit ripple adder.
- Computes `a - b` digit-serially, processing DIGIT_W bits per cycle through one narrow subtract slice with a registered borrow.
- Used where area matters more than latency: the ALU slow path, address-decrement units and the bench reference for the adder catalog.
- Valid/ready handshake on both the input and output sides.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT_W, 1, bits processed per cycle. WIDTH % DIGIT_W must be 0; any other value is an elaboration-time error.

Ports:
- clk  input  1  single clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  `a - b`, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; equals 1 iff a < b (unsigned).
- zero  output  1  diff == 0.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - diff = 0, borrow_out = 0, zero = 0, ovf = 0.
  - Internal operand shift registers, borrow register and counter are all cleared.
- States: IDLE, RUN, DONE. Encoding is in the package.
- IDLE:
  - in_ready = 1.
  - On `in_valid && in_ready` at an edge: latch a and b into shift registers, borrow = 0, cnt = 0, capture a[WIDTH-1] and b[WIDTH-1] for ovf, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle the slice computes `{borrow', d} = a_sh[DIGIT_W-1:0] - b_sh[DIGIT_W-1:0] - borrow`.
  - d is shifted into the MSB end of the result register. a_sh and b_sh shift right by DIGIT_W. The borrow register takes borrow'.
  - cnt increments. On the edge where cnt == N-1 (N = WIDTH/DIGIT_W), go to DONE.
- Latency: operands accepted at edge 0 give out_valid high after edge N. That is 32 cycles for DIGIT_W=1 and 8 cycles for DIGIT_W=4.
- DONE:
  - out_valid = 1.
  - diff = result register, borrow_out = final borrow, zero = (diff == 0).
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
  - Outputs hold stable while `out_ready` = 0, for an unlimited number of cycles.
  - On `out_valid && out_ready`, go to IDLE. out_valid drops the next cycle and in_ready rises.
  - No new operand is accepted in the same cycle as the output transfer: minimum initiation interval is N+2 cycles.
- Output values:
  - diff, borrow_out, zero and ovf are registered. They keep their last value after returning to IDLE and are only meaningful while out_valid = 1.
  - zero and ovf are evaluated in DONE from registered values. They are not combinational on live inputs.
- Input stability: a and b are sampled only at acceptance. Changes during RUN have no effect.
- in_valid during RUN or DONE is ignored, with no queuing.
- Reset mid-RUN or mid-DONE: the operation is aborted, no output transfer occurs, and all outputs return to their reset values.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Borrow is never carried into a subsequent operation.
  - The slice borrow-in is forced to 0 on the first digit.

Decomposition:
- Package sub_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Default WIDTH/DIGIT_W constants.
  - A function computing N and the counter width, $clog2(N) with a minimum of 1.
- Sub-module sub_slice:
  - Combinational DIGIT_W-bit subtractor.
  - Inputs: x, y, bin. Outputs: d, bout.
  - Built as an adder of x, ~y and carry-in !bin, with bout = !cout.
- serial_sub32 holds the FSM, counter, shift registers and flag logic.

Test Plan:
- a=5, b=3, DIGIT_W=1 -> out_valid exactly 32 cycles after acceptance; diff=0x00000002, borrow_out=0, zero=0, ovf=0.
- a=0, b=1 -> diff=0xFFFFFFFF, borrow_out=1, zero=0, ovf=0.
- a=0x80000000, b=1 -> diff=0x7FFFFFFF, borrow_out=0, ovf=1. Then a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, borrow_out=1, ovf=1.
- a=b=0xDEADBEEF with out_ready held low 5 cycles after out_valid -> diff=0, zero=1; outputs stable all 5 cycles; in_ready stays 0 until one cycle after the transfer; in_valid pulses during RUN are ignored.
- DIGIT_W=4, a=0x12345678, b=0x11111111 -> out_valid 8 cycles after acceptance; diff=0x01234567, borrow_out=0.
- rst_n asserted asynchronously mid-RUN (cycle 10) -> out_valid=0 and in_ready=1 immediately; a fresh a=10, b=4 after release -> diff=6 with normal latency.
